// File: rtl/data_axi_master.sv
// Data-side AXI4 master: turns one MEM-stage request into a single-beat AXI read or write.
// Minimum latency is 3 busy cycles, with the result in DONE; any ready/valid low simply holds the current state.
module data_axi_master #(
    parameter int          ID_WIDTH   = 4,
    parameter int unsigned ID_VAL     = 1,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_ce,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [3:0]            req_sel,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  resp_err_o,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_t;

    state_t                state_q;
    logic [31:0]           addr_q;
    logic [3:0]            sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            size_q;
    logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                  aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    // Single-beat transfers only, so the last-beat marker carries no information.
    logic unused_rlast;
    assign unused_rlast = rlast;

    function automatic logic [2:0] sel_to_size(input logic [3:0] s);
        case (s)
            4'b0011, 4'b1100:                   return 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
            default:                            return 3'd2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            size_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_ce) begin
                        addr_q <= req_addr;
                        sel_q  <= req_sel;
                        data_q <= req_data;
                        size_q <= sel_to_size(req_sel);
                        if (req_we) begin
                            state_q   <= S_AWW;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= rdata;
                        err_q    <= (rresp != 2'b00);
                        state_q  <= S_DONE;
                    end
                end
                S_AWW: begin
                    // AW and W retire independently; leave once both have handshaken.
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || awready) && (w_done_q || wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        err_q    <= (bresp != 2'b00);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Holding here while MEM is stalled elsewhere keeps the request from re-issuing.
                    if (!stall_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q == S_IDLE) ? req_ce : (state_q != S_DONE);
    assign rdata_o    = rdata_q;
    assign resp_err_o = err_q;

    assign arid    = ID_WIDTH'(ID_VAL);
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = ID_WIDTH'(ID_VAL);
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awvalid = awvalid_q;
    assign wdata   = data_q;
    assign wstrb   = sel_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_data_axi_master.sv
// Directed bench for data_axi_master: table of single transactions plus reset sequences.
module tb_data_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ce, req_we;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_sel;
    logic        stall_i;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        resp_err_o;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    data_axi_master #(.ID_WIDTH(4), .ID_VAL(1), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr), .req_sel(req_sel),
        .req_data(req_data), .stall_i(stall_i),
        .busy_o(busy_o), .rdata_o(rdata_o), .resp_err_o(resp_err_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          aw_delay;
        int          stall_n;
        int          exp_busy;
        logic [2:0]  exp_size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam logic [14:0] FIXED = {1'b1, 8'h00, 2'b01, 4'h1};

    vec_t vecs[8];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    // Runs one request against a responsive slave; next request follows with no gap.
    task automatic run_txn(input int idx, input vec_t v);
        int          busy_n = 0, arv_n = 0, awv_n = 0, wv_n = 0, dn_n = 0;
        bit          fin = 1'b0;
        logic [31:0] cap_addr = '0, cap_wdata = '0, cap_rd = '0;
        logic [3:0]  cap_wstrb = '0;
        logic [2:0]  cap_size = '0;
        logic [14:0] cap_fix = '0;
        logic        cap_err = 1'b0;
        string       p;
        p = $sformatf("v%0d_", idx);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            req_ce = 1'b1; req_we = v.we; req_addr = v.addr; req_sel = v.sel; req_data = v.data;
            arready = 1'b1; wready = 1'b1; awready = (awv_n >= v.aw_delay);
            rvalid = rready; rdata = v.rd; rresp = v.resp;
            bvalid = bready; bresp = v.resp;
            stall_i = (dn_n < v.stall_n);
            #1;
            if (cyc == 0) chk({p, "busy_first"}, 32'(busy_o), 32'd1);
            if (arvalid) begin
                arv_n++; cap_addr = araddr; cap_size = arsize; cap_fix = {1'b1, arlen, arburst, arid};
            end
            if (awvalid) begin
                awv_n++; cap_addr = awaddr; cap_size = awsize; cap_fix = {wlast, awlen, awburst, awid};
            end
            if (wvalid) begin
                wv_n++; cap_wdata = wdata; cap_wstrb = wstrb;
            end
            if (busy_o) busy_n++;
            else if (cyc > 0) begin
                if (dn_n == 0) begin cap_rd = rdata_o; cap_err = resp_err_o; end
                dn_n++;
                if (!stall_i) fin = 1'b1;
            end
        end
        chk({p, "finished"}, 32'(fin), 32'd1);
        chk({p, "busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
        chk({p, "done_cycles"}, 32'(dn_n), 32'(v.stall_n + 1));
        chk({p, "addr"}, cap_addr, v.addr);
        chk({p, "size"}, 32'(cap_size), 32'(v.exp_size));
        chk({p, "fixed"}, 32'(cap_fix), 32'(FIXED));
        chk({p, "rdata_o"}, cap_rd, v.exp_rdata);
        chk({p, "resp_err"}, 32'(cap_err), 32'(v.exp_err));
        if (v.we) begin
            chk({p, "awvalid_cycles"}, 32'(awv_n), 32'(v.aw_delay + 1));
            chk({p, "wvalid_cycles"}, 32'(wv_n), 32'd1);
            chk({p, "arvalid_cycles"}, 32'(arv_n), 32'd0);
            chk({p, "wdata"}, cap_wdata, v.data);
            chk({p, "wstrb"}, 32'(cap_wstrb), 32'(v.sel));
        end else begin
            chk({p, "arvalid_cycles"}, 32'(arv_n), 32'd1);
            chk({p, "awvalid_cycles"}, 32'(awv_n), 32'd0);
        end
    endtask

    task automatic chk_idle_outputs(input string p);
        chk({p, "valids"}, 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk({p, "busy"}, 32'(busy_o), 32'd0);
        chk({p, "rdata_o"}, rdata_o, 32'd0);
        chk({p, "resp_err"}, 32'(resp_err_o), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h1C000104, 4'b1111, 32'h0,        32'hDEADBEEF, 2'b00, 0, 0, 3, 3'd2, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h1C000003, 4'b1000, 32'hAAAAAAAA, 32'h0,        2'b00, 3, 0, 6, 3'd0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h1C000010, 4'b0011, 32'h0,        32'h12345678, 2'b10, 0, 0, 3, 3'd1, 32'h12345678, 1'b1};
        vecs[3] = '{1'b1, 32'h1C000020, 4'b1100, 32'h55AA55AA, 32'h0,        2'b00, 0, 0, 3, 3'd1, 32'h12345678, 1'b0};
        vecs[4] = '{1'b1, 32'h1C000030, 4'b0000, 32'h11111111, 32'h0,        2'b00, 0, 0, 3, 3'd2, 32'h12345678, 1'b0};
        vecs[5] = '{1'b0, 32'h1C000040, 4'b0101, 32'h0,        32'hCAFEF00D, 2'b00, 0, 0, 3, 3'd2, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b1, 32'h1C000041, 4'b0001, 32'h77777777, 32'h0,        2'b11, 0, 0, 3, 3'd0, 32'hCAFEF00D, 1'b1};
        vecs[7] = '{1'b0, 32'h1C000046, 4'b0100, 32'h0,        32'h0BADF00D, 2'b00, 0, 2, 3, 3'd0, 32'h0BADF00D, 1'b0};

        rst = 1'b1; req_ce = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0; req_data = '0;
        stall_i = 1'b0; arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset_");
        chk("reset_addr_size", {araddr[28:0], arsize}, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        chk("reset_wstrb", 32'(wstrb), 32'd0);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Reset while the R beat is still outstanding.
        @(negedge clk);
        req_ce = 1'b1; req_we = 1'b0; req_addr = 32'h1C000200; req_sel = 4'b1111;
        arready = 1'b1; rvalid = 1'b0; bvalid = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        req_ce = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_in_R", 32'({rready, busy_o}), 32'b11);
        chk("rst_mid_rdata_before", rdata_o, 32'h0BADF00D);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_outputs("rst_mid_");
        @(negedge clk);
        #1;
        chk("rst_mid_stays_idle", 32'({arvalid, busy_o}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
